// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: scanout-priority, round-robin arbiter sharing one single-port framebuffer RAM.
// Optional macro FB_VBLANK_WRITE_EN restricts draw-engine writes to vertical blanking.
module vga_fb_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              vblank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_RD} tag_t;

    logic              wr_elig, g_disp, g_wr, g_rd;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_t              tag1_q, tag1_d, tag2_q, tag2_d;
    logic              disp_valid_q, disp_valid_d, rd_rvalid_q, rd_rvalid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d, rd_rdata_q, rd_rdata_d;

`ifdef FB_VBLANK_WRITE_EN
    assign wr_elig = wr_valid & vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign wr_elig = wr_valid;
`endif

    // Scanout always wins; otherwise rr breaks a writer/reader tie.
    assign g_disp = !rst && disp_req;
    assign g_wr   = !rst && !disp_req && wr_elig && (!rd_valid || !rr_q);
    assign g_rd   = !rst && !disp_req && rd_valid && (!wr_elig || rr_q);

    assign wr_ready = g_wr;
    assign rd_ready = g_rd;

    always_comb begin
        rr_d        = g_wr ? 1'b1 : g_rd ? 1'b0 : rr_q;
        mem_addr_d  = g_disp ? disp_addr : g_wr ? wr_addr : g_rd ? rd_addr : mem_addr_q;
        mem_we_d    = g_wr;
        mem_wdata_d = g_wr ? wr_data : mem_wdata_q;
        tag1_d      = g_disp ? TAG_DISP : g_rd ? TAG_RD : TAG_NONE;
        tag2_d      = tag1_q;
        disp_valid_d = tag2_q == TAG_DISP;
        rd_rvalid_d  = tag2_q == TAG_RD;
        disp_data_d  = tag2_q == TAG_DISP ? mem_rdata : disp_data_q;
        rd_rdata_d   = tag2_q == TAG_RD ? mem_rdata : rd_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            disp_valid_q <= 1'b0;
            rd_rvalid_q  <= 1'b0;
            disp_data_q  <= '0;
            rd_rdata_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            disp_valid_q <= disp_valid_d;
            rd_rvalid_q  <= rd_rvalid_d;
            disp_data_q  <= disp_data_d;
            rd_rdata_q   <= rd_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign rd_rvalid  = rd_rvalid_q;
    assign rd_rdata   = rd_rdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed vector table plus hand-written sequences for vga_fb_arbiter,
// with a write-first 1-cycle-latency RAM model and a shadow-memory scoreboard.
module tb_vga_fb_arbiter;
    localparam int AW = 17;
    localparam int DW = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          disp_req = 1'b0, wr_valid = 1'b0, rd_valid = 1'b0, vblank = 1'b1;
    logic [AW-1:0] disp_addr = '0, wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0, mem_rdata = '0;
    logic          disp_valid, wr_ready, rd_ready, rd_rvalid, mem_we;
    logic [DW-1:0] disp_data, rd_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int total = 0, passed = 0, cyc = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .vblank(vblank),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_w(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {15'h0, a};
    endfunction

    // Write-first single-port RAM; unwritten words read back as init_w(addr).
    logic [DW-1:0] ram [int];
    always @(posedge clk) begin
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
        mem_rdata <= mem_we ? mem_wdata :
                     (ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_w(mem_addr));
    end

    logic [DW-1:0] sh [int];
    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return sh.exists(int'(a)) ? sh[int'(a)] : init_w(a);
    endfunction

    typedef struct packed { logic d, w, r, ew, er; logic [1:0] sel; } vec_t;
    typedef struct { int c; logic [DW-1:0] d; } rsp_t;
    vec_t tbl [12];
    rsp_t dq[$], rq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        disp_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_rsp;
        logic e;
        e = dq.size() > 0 && dq[0].c == cyc;
        chk("mix_disp_valid", disp_valid, e);
        if (e) begin
            chk("mix_disp_data", disp_data, dq[0].d);
            void'(dq.pop_front());
        end
        e = rq.size() > 0 && rq[0].c == cyc;
        chk("mix_rd_rvalid", rd_rvalid, e);
        if (e) begin
            chk("mix_rd_rdata", rd_rdata, rq[0].d);
            void'(rq.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [AW-1:0] exp_addr;
        logic rr_m, gw, gr;
        // d, w, r, expected wr_ready, expected rd_ready, granted (0 none 1 disp 2 wr 3 rd)
        tbl = '{'{1'b0,1'b1,1'b1,1'b1,1'b0,2'd2}, '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd3},
                '{1'b1,1'b1,1'b1,1'b0,1'b0,2'd1}, '{1'b0,1'b1,1'b1,1'b1,1'b0,2'd2},
                '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0}, '{1'b0,1'b1,1'b0,1'b1,1'b0,2'd2},
                '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd3}, '{1'b0,1'b0,1'b1,1'b0,1'b1,2'd3},
                '{1'b0,1'b1,1'b1,1'b1,1'b0,2'd2}, '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,1'b1,1'b0,1'b1,2'd3}, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0}};

        // Reset state, with every requester active while rst is high.
        disp_req = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        tick(); tick();
        #3;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_rd_rvalid", rd_rvalid, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_rd_rdata", rd_rdata, 0);
        tick();
        rst = 1'b0;

        // Vector table: grant decisions and the registered command they produce.
        exp_addr = '0;
        for (int i = 0; i < 12; i++) begin
            disp_req = tbl[i].d; wr_valid = tbl[i].w; rd_valid = tbl[i].r;
            disp_addr = AW'(32'h10 + i); wr_addr = AW'(32'h20 + i); rd_addr = AW'(32'h30 + i);
            wr_data = 32'h1000_0000 + i;
            #3;
            chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].ew);
            chk($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].er);
            tick();
            exp_addr = tbl[i].sel == 2'd1 ? AW'(32'h10 + i) : tbl[i].sel == 2'd2 ? AW'(32'h20 + i) :
                       tbl[i].sel == 2'd3 ? AW'(32'h30 + i) : exp_addr;
            chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].sel == 2'd2);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, exp_addr);
            if (tbl[i].sel == 2'd2) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, 32'h1000_0000 + i);
        end
        idle(3);

        // Scanout priority: 8 back-to-back scanout reads starve a waiting writer.
        for (int c = 0; c < 12; c++) begin
            disp_req = c < 8; disp_addr = AW'(c);
            wr_valid = c <= 8; wr_addr = AW'(32'h200); wr_data = 32'h2222_0000; rd_valid = 1'b0;
            #3;
            chk($sformatf("scan%0d_wr_ready", c), wr_ready, c == 8);
            tick();
            k = c + 1;
            chk($sformatf("scan%0d_disp_valid", k), disp_valid, k >= 3 && k <= 10);
            if (k >= 3 && k <= 10) chk($sformatf("scan%0d_disp_data", k), disp_data, init_w(AW'(k - 3)));
            if (k == 11) chk("scan_disp_data_hold", disp_data, init_w(AW'(7)));
        end

        // Round-robin from reset: W,R,W,R... with read data 3 cycles after each read accept.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            wr_valid = c < 8; rd_valid = c < 8;
            wr_addr = AW'(32'h400); wr_data = 32'h4444_0000 + c; rd_addr = AW'(32'h300);
            #3;
            chk($sformatf("rr%0d_wr_ready", c), wr_ready, c < 8 && c % 2 == 0);
            chk($sformatf("rr%0d_rd_ready", c), rd_ready, c < 8 && c % 2 == 1);
            tick();
            k = c + 1;
            chk($sformatf("rr%0d_rd_rvalid", k), rd_rvalid, k == 4 || k == 6 || k == 8 || k == 10);
            if (k == 4 || k == 6 || k == 8 || k == 10)
                chk($sformatf("rr%0d_rd_rdata", k), rd_rdata, init_w(AW'(32'h300)));
        end
        idle(3);

        // Read-after-write to the same address in the next slot.
        wr_valid = 1'b1; wr_addr = AW'(32'h100); wr_data = 32'hDEAD_BEEF; rd_valid = 1'b0;
        #3 chk("raw_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = AW'(32'h100);
        #3 chk("raw_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        for (int j = 2; j <= 6; j++) begin
            chk($sformatf("raw%0d_rd_rvalid", j), rd_rvalid, j == 4);
            if (j >= 4) chk($sformatf("raw%0d_rd_rdata", j), rd_rdata, 32'hDEAD_BEEF);
            if (j < 6) tick();
        end
        idle(3);

        // Asynchronous reset with two game reads in flight.
        rd_valid = 1'b1; rd_addr = AW'(32'h300);
        tick(); tick();
        rd_valid = 1'b0; wr_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_rd_rdata", rd_rdata, 0);
        chk("mrst_disp_data", disp_data, 0);
        chk("mrst_rd_rvalid", rd_rvalid, 0);
        chk("mrst_disp_valid", disp_valid, 0);
        chk("mrst_wr_ready", wr_ready, 0);
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("mrst%0d_rd_rvalid", j), rd_rvalid, 0);
            chk($sformatf("mrst%0d_disp_valid", j), disp_valid, 0);
            tick();
        end

        // Write gating by vblank.
        wr_valid = 1'b1; wr_addr = AW'(32'h500); wr_data = 32'h5555_5555; vblank = 1'b0;
`ifdef FB_VBLANK_WRITE_EN
        for (int c = 0; c < 20; c++) begin
            #3 chk($sformatf("vb%0d_wr_ready", c), wr_ready, 0);
            tick();
            chk($sformatf("vb%0d_mem_we", c), mem_we, 0);
        end
        vblank = 1'b1;
        #3 chk("vb_open_wr_ready", wr_ready, 1);
        tick();
        chk("vb_open_mem_we", mem_we, 1);
`else
        #3 chk("novb_wr_ready", wr_ready, 1);
        tick();
        chk("novb_mem_we", mem_we, 1);
`endif
        vblank = 1'b1;
        idle(3);

        // Mixed traffic against a shadow-memory scoreboard.
        do_reset();
        rr_m = 1'b0;
        for (int c = 0; c < 1004; c++) begin
            check_rsp();
            disp_req  = c < 1000 && c % 4 == 0;
            wr_valid  = c < 1000 && $urandom_range(0, 1) == 1;
            rd_valid  = c < 1000 && $urandom_range(0, 1) == 1;
            disp_addr = AW'(32'h800 + $urandom_range(0, 63));
            wr_addr   = AW'(32'h800 + $urandom_range(0, 63));
            rd_addr   = AW'(32'h800 + $urandom_range(0, 63));
            wr_data   = $urandom;
            #3;
            gw = !disp_req && wr_valid && (!rd_valid || !rr_m);
            gr = !disp_req && rd_valid && (!wr_valid || rr_m);
            chk("mix_wr_ready", wr_ready, gw);
            chk("mix_rd_ready", rd_ready, gr);
            if (disp_req) dq.push_back('{cyc + 3, sh_rd(disp_addr)});
            if (gw) begin
                sh[int'(wr_addr)] = wr_data;
                rr_m = 1'b1;
            end
            if (gr) begin
                rq.push_back('{cyc + 3, sh_rd(rd_addr)});
                rr_m = 1'b0;
            end
            tick();
        end
        check_rsp();
        chk("mix_disp_drained", dq.size(), 0);
        chk("mix_rd_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (1-cycle read latency) between three requesters:
  - VGA scanout reader: hard real-time, fixed latency.
  - Draw-engine writer.
  - Game-logic reader.
- Scanout always wins. Writer and game reader share the remaining slots round-robin.
- Sits between the VGA timing/pixel path and the framebuffer RAM; all RAM command outputs are registered.

Parameters:
- ADDR_W, 17, framebuffer word address width (640x480 at 4 pixels/word = 76800 words).
- DATA_W, 32, framebuffer word width.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- disp_req  in  1  scanout read request; may be asserted every cycle; never back-pressured.
- disp_addr  in  ADDR_W  scanout word address.
- disp_valid  out  1  scanout data valid pulse.
- disp_data  out  DATA_W  scanout read data.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer accept (combinational).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  game read request.
- rd_ready  out  1  game read accept (combinational).
- rd_addr  in  ADDR_W  game read address.
- rd_rvalid  out  1  game read data valid pulse.
- rd_rdata  out  DATA_W  game read data.
- vblank  in  1  high during vertical blanking (from timing generator); used only with the optional feature.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Grant in cycle N is decided combinationally from that cycle's inputs:
  - disp_req=1: scanout granted; wr_ready=0, rd_ready=0.
  - Otherwise, if exactly one of wr_valid/rd_valid is high, that requester is granted.
  - Otherwise, if both are high, the round-robin pointer decides.
  - wr_ready is never asserted without wr_valid; rd_ready likewise.
- Round-robin pointer rr:
  - 0 = writer favoured, 1 = game reader favoured.
  - Updates only on a writer or game-reader grant: set to 1 after a write grant, 0 after a read grant.
  - Scanout grants and idle cycles leave rr unchanged.
- Command register:
  - Cycle N+1 shows mem_addr/mem_we/mem_wdata of the cycle-N grant.
  - With no grant, mem_we=0 and mem_addr/mem_wdata hold their previous values.
  - mem_we=1 only for a writer grant.
- Return tracking: a 2-stage tag pipeline, tag values NONE/DISP/RD.
  - The tag is launched with the command in cycle N+1 and is aligned with mem_rdata in cycle N+2.
  - mem_rdata is registered into disp_data or rd_rdata.
- Latency: disp_valid / rd_rvalid pulse for exactly one cycle, in cycle N+3 after acceptance in cycle N. The latency is fixed and independent of other traffic.
- Ordering: responses return in acceptance order.
- A write followed by a read to the same address in the next slot returns the new data; the RAM is write-first and the arbiter does nothing extra.
- disp_data and rd_rdata hold their value between valid pulses.
- Continuous disp_req starves writer and game reader indefinitely. This is by design; the scanout duty cycle guarantees free slots.
- Reset (any time, asynchronous):
  - All outputs to 0: mem_*, disp_valid, disp_data, rd_rvalid, rd_rdata.
  - rr=0 and tag pipeline cleared to NONE.
  - Reads in flight are discarded; no valid pulse appears for them after reset deasserts.
- While rst=1: wr_ready=0 and rd_ready=0 regardless of inputs.
- First cycle after reset deassertion: normal arbitration.

Optional Feature:
- Macro: FB_VBLANK_WRITE_EN.
- Defined: writer grants only while vblank=1 (tear-free update). When vblank=0, wr_ready=0 and rd_valid alone may be granted. rr is unaffected by blocked writes.
- Not defined: vblank is ignored; behaviour as above.

Test Plan:
- Reset: assert rst mid-stream with 2 reads in flight -> all outputs 0 immediately; no disp_valid/rd_rvalid after release.
- Scanout priority: disp_req=1 with addr 0..7 over 8 cycles, wr_valid=1 throughout -> wr_ready=0 for all 8 cycles; disp_valid pulses cycles 3..10 with the RAM model's data for 0..7; write accepted the cycle disp_req drops.
- Round-robin: wr_valid=rd_valid=1 continuously, disp_req=0 -> grants alternate W,R,W,R starting with W after reset; rd_rvalid 3 cycles after each read accept.
- Read-after-write: write 0xDEADBEEF to addr 0x100, then game read of 0x100 next cycle -> rd_rdata=0xDEADBEEF.
- Mixed latency: interleave disp_req every 4th cycle with random wr/rd traffic for 1000 cycles -> every disp_valid exactly 3 cycles after its request; data matches scoreboard; no lost or duplicated responses.
- FB_VBLANK_WRITE_EN: vblank=0, wr_valid=1 for 20 cycles -> no write; raise vblank -> write accepted in the same cycle.
